// File: rtl/mult_pkg.sv
// Shared types and constants for the signed-magnitude multiplier sequencer.
package mult_pkg;

    localparam int MULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mult_state_t;

    // Width of an iteration counter that must be able to hold the value w.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/mult_shift_add_dp.sv
// Radix-2 shift-add datapath: multiplicand, multiplier, accumulator and iteration count.
// Optional macro EARLY_TERM_EN adds a done condition on an exhausted multiplier.
module mult_shift_add_dp
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 step,
    input  logic [WIDTH-1:0]     numero1,
    input  logic [WIDTH-1:0]     numero2,
    output logic [2*WIDTH-1:0]   acc_next,
    output logic                 done
);

    localparam int CW = cnt_width(WIDTH);

    logic [2*WIDTH-1:0] mcand_r;
    logic [WIDTH-1:0]   mplier_r;
    logic [2*WIDTH-1:0] acc_r;
    logic [CW-1:0]      cnt_r;
    logic [WIDTH-1:0]   mplier_next_s;
    logic               last_s;

    // Accumulator value after this cycle's conditional add, and the final-iteration flag.
    always_comb begin
        acc_next      = acc_r + (mplier_r[0] ? mcand_r : {(2*WIDTH){1'b0}});
        mplier_next_s = mplier_r >> 1;
        last_s        = (cnt_r == CW'(WIDTH - 1));
`ifdef EARLY_TERM_EN
        done          = last_s | (mplier_next_s == {WIDTH{1'b0}});
`else
        done          = last_s;
`endif
    end

    // Operand load and one add-shift iteration per step.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mcand_r  <= {(2*WIDTH){1'b0}};
            mplier_r <= {WIDTH{1'b0}};
            acc_r    <= {(2*WIDTH){1'b0}};
            cnt_r    <= {CW{1'b0}};
        end else if (load) begin
            mcand_r  <= {{WIDTH{1'b0}}, numero1};
            mplier_r <= numero2;
            acc_r    <= {(2*WIDTH){1'b0}};
            cnt_r    <= {CW{1'b0}};
        end else if (step) begin
            mcand_r  <= mcand_r << 1;
            mplier_r <= mplier_next_s;
            acc_r    <= acc_next;
            cnt_r    <= cnt_r + CW'(1);
        end else begin
            mcand_r  <= mcand_r;
            mplier_r <= mplier_r;
            acc_r    <= acc_r;
            cnt_r    <= cnt_r;
        end
    end

endmodule

// File: rtl/mult_sequencer.sv
// Sequencer for the signed-magnitude multiplier: handshake FSM, sign tracking and held result.
// Optional macro EARLY_TERM_EN: stop iterating once the multiplier is exhausted.
module mult_sequencer
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     numero1,
    input  logic [WIDTH-1:0]     numero2,
    input  logic                 signo1,
    input  logic                 signo2,
    output logic [2*WIDTH-1:0]   producto,
    output logic                 signo_p,
    output logic                 result_valid,
    input  logic                 result_ack,
    output logic                 busy
);

    mult_state_t        state_r;
    mult_state_t        next_state_s;
    logic               load_s;
    logic               step_s;
    logic               finish_s;
    logic               zero_done_s;
    logic               clear_s;
    logic               zero_op_s;
    logic               sgn_r;
    logic [2*WIDTH-1:0] acc_next_s;
    logic               dp_done_s;
    logic [2*WIDTH-1:0] producto_r;
    logic               signo_p_r;
    logic               result_valid_r;

    mult_shift_add_dp #(.WIDTH(WIDTH)) u_dp (
        .clk      (clk),
        .rst      (rst),
        .load     (load_s),
        .step     (step_s),
        .numero1  (numero1),
        .numero2  (numero2),
        .acc_next (acc_next_s),
        .done     (dp_done_s)
    );

    assign in_ready     = (state_r != RUN);
    assign busy         = (state_r == RUN);
    assign producto     = producto_r;
    assign signo_p      = signo_p_r;
    assign result_valid = result_valid_r;

    // Next-state and datapath strobes; a new handshake in DONE doubles as the ack.
    always_comb begin
        next_state_s = state_r;
        load_s       = 1'b0;
        step_s       = 1'b0;
        finish_s     = 1'b0;
        zero_done_s  = 1'b0;
        clear_s      = 1'b0;
`ifdef EARLY_TERM_EN
        zero_op_s    = (numero2 == {WIDTH{1'b0}});
`else
        zero_op_s    = 1'b0;
`endif
        case (state_r)
            IDLE, DONE: begin
                if (in_valid) begin
                    load_s = 1'b1;
                    if (zero_op_s) begin
                        zero_done_s  = 1'b1;
                        next_state_s = DONE;
                    end else begin
                        next_state_s = RUN;
                    end
                end else if ((state_r == DONE) && result_ack) begin
                    clear_s      = 1'b1;
                    next_state_s = IDLE;
                end else begin
                    next_state_s = state_r;
                end
            end
            RUN: begin
                step_s = 1'b1;
                if (dp_done_s) begin
                    finish_s     = 1'b1;
                    next_state_s = DONE;
                end else begin
                    next_state_s = RUN;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Product sign latch and result registers; a zero product never carries a negative sign.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sgn_r          <= 1'b0;
            producto_r     <= {(2*WIDTH){1'b0}};
            signo_p_r      <= 1'b0;
            result_valid_r <= 1'b0;
        end else begin
            if (load_s) begin
                sgn_r <= signo1 ^ signo2;
            end else begin
                sgn_r <= sgn_r;
            end
            if (finish_s) begin
                producto_r     <= acc_next_s;
                signo_p_r      <= sgn_r & (|acc_next_s);
                result_valid_r <= 1'b1;
            end else if (zero_done_s) begin
                producto_r     <= {(2*WIDTH){1'b0}};
                signo_p_r      <= 1'b0;
                result_valid_r <= 1'b1;
            end else if (load_s || clear_s) begin
                result_valid_r <= 1'b0;
            end else begin
                result_valid_r <= result_valid_r;
            end
        end
    end

endmodule

// File: tb/tb_mult_sequencer.sv
// Scoreboard bench for mult_sequencer: directed operand pairs, monitor checks each result.
module tb_mult_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  numero1 = 8'd0;
    logic [7:0]  numero2 = 8'd0;
    logic        signo1 = 1'b0;
    logic        signo2 = 1'b0;
    logic [15:0] producto;
    logic        signo_p;
    logic        result_valid;
    logic        result_ack = 1'b0;
    logic        busy;

    typedef struct {
        logic [15:0] p;
        logic        s;
        int          due;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;
    int   cyc    = 0;
    int   cyc_hs = 0;
    logic prev_rv = 1'b0;

    mult_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .numero1      (numero1),
        .numero2      (numero2),
        .signo1       (signo1),
        .signo2       (signo2),
        .producto     (producto),
        .signo_p      (signo_p),
        .result_valid (result_valid),
        .result_ack   (result_ack),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int exp_lat(input logic [7:0] n2);
        int l;
        l = 8;
`ifdef EARLY_TERM_EN
        l = 1;
        for (int i = 0; i < 8; i++) begin
            if (n2[i]) l = i + 1;
        end
`endif
        return l;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: each rising result_valid must match the oldest expectation, including its arrival cycle.
    always @(negedge clk) begin
        if (!rst) begin
            prev_rv = 1'b0;
        end else begin
            if (result_valid && !prev_rv) begin
                n_vec++;
                if (sb_q.size() == 0) begin
                    n_miss++;
                    $display("FAIL unexpected_result: got producto %0d signo_p %0d with nothing pending", producto, signo_p);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    if (producto !== e.p || signo_p !== e.s || cyc != e.due) begin
                        n_miss++;
                        $display("FAIL result: got producto %0d signo_p %0d at cycle %0d, expected %0d %0d at cycle %0d",
                                 producto, signo_p, cyc, e.p, e.s, e.due);
                    end
                end
            end
            prev_rv = result_valid;
        end
    end

    task automatic do_op(input logic [7:0] a, input logic sa, input logic [7:0] b, input logic sb,
                         input logic [15:0] ep, input logic es, input bit push);
        int  tries;
        exp_t e;
        tries = 0;
        @(negedge clk);
        while (!in_ready && tries < 40) begin
            @(negedge clk);
            tries++;
        end
        if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
        numero1  = a;
        signo1   = sa;
        numero2  = b;
        signo2   = sb;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cyc_hs   = cyc;
        if (push) begin
            e.p = ep;
            e.s = es;
            e.due = cyc_hs + exp_lat(b);
            sb_q.push_back(e);
        end
    endtask

    task automatic wait_rv();
        int n;
        n = 0;
        @(negedge clk);
        while (!result_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!result_valid) chk("result_timeout", 32'(result_valid), 32'd1);
    endtask

    task automatic ack();
        @(negedge clk);
        result_ack = 1'b1;
        @(posedge clk);
        #1;
        result_ack = 1'b0;
        chk("ack_rv", 32'(result_valid), 32'd0);
        chk("ack_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_producto", 32'(producto), 32'd0);
        chk("rst_rv", 32'(result_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", 32'(in_ready), 32'd1);

        do_op(8'd12, 1'b0, 8'd5, 1'b1, 16'd60, 1'b1, 1'b1);
        chk("run_in_ready", 32'(in_ready), 32'd0);
        chk("run_busy", 32'(busy), 32'd1);
        wait_rv();
        chk("done_busy", 32'(busy), 32'd0);
        ack();

        do_op(8'd99, 1'b1, 8'd99, 1'b1, 16'd9801, 1'b0, 1'b1);
        wait_rv();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("hold_producto", 32'(producto), 32'd9801);
            chk("hold_rv", 32'(result_valid), 32'd1);
            chk("hold_signo_p", 32'(signo_p), 32'd0);
        end
        ack();

        do_op(8'd0, 1'b1, 8'd7, 1'b0, 16'd0, 1'b0, 1'b1);
        wait_rv();
        ack();
        do_op(8'd7, 1'b1, 8'd0, 1'b0, 16'd0, 1'b0, 1'b1);
        wait_rv();
        ack();

        // Reset in the middle of a multiplication: nothing of 13x11 may surface.
        do_op(8'd13, 1'b0, 8'd11, 1'b0, 16'd143, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_producto", 32'(producto), 32'd0);
        chk("midrst_rv", 32'(result_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        do_op(8'd3, 1'b0, 8'd4, 1'b0, 16'd12, 1'b0, 1'b1);
        wait_rv();
        ack();

        // New operands accepted straight out of DONE without an ack.
        do_op(8'd6, 1'b0, 8'd7, 1'b0, 16'd42, 1'b0, 1'b1);
        wait_rv();
        do_op(8'd2, 1'b1, 8'd9, 1'b0, 16'd18, 1'b1, 1'b1);
        chk("implicit_ack_rv", 32'(result_valid), 32'd0);
        chk("implicit_ack_old_producto", 32'(producto), 32'd42);
        chk("implicit_ack_busy", 32'(busy), 32'd1);
        @(negedge clk);
        numero1  = 8'd50;
        numero2  = 8'd3;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        wait_rv();
        ack();

        do_op(8'd200, 1'b0, 8'd1, 1'b0, 16'd200, 1'b0, 1'b1);
        wait_rv();
        ack();
        do_op(8'd255, 1'b0, 8'd255, 1'b1, 16'd65025, 1'b1, 1'b1);
        wait_rv();
        ack();

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
